// File: rtl/emu_periph_pkg.sv
// Shared definitions for the emulator peripherals: register indices, CTRL bits, AXI response codes.
// Also holds the byte-strobe merge helper used by the register write paths.
package emu_periph_pkg;

  typedef enum logic [2:0] {
    REG_MTIME_LO = 3'd0,
    REG_MTIME_HI = 3'd1,
    REG_CMP_LO   = 3'd2,
    REG_CMP_HI   = 3'd3,
    REG_CTRL     = 3'd4
  } reg_idx_t;

  localparam logic [7:0] OFF_MTIME_LO = 8'h00;
  localparam logic [7:0] OFF_MTIME_HI = 8'h04;
  localparam logic [7:0] OFF_CMP_LO   = 8'h08;
  localparam logic [7:0] OFF_CMP_HI   = 8'h0C;
  localparam logic [7:0] OFF_CTRL     = 8'h10;

  localparam int CTRL_EN_BIT = 0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

  function automatic logic idx_mapped(input logic [2:0] idx);
    return (idx <= 3'd4);
  endfunction

endpackage

// File: rtl/axil_timer_core.sv
// Timer datapath: prescaler, 64-bit mtime, compare register, enable and registered irq.
// Register writes arrive already decoded as a register index plus data and byte strobes.
module axil_timer_core
  import emu_periph_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_idx,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic [63:0] mtime,
  output logic [63:0] cmp,
  output logic        en,
  output logic        irq
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  logic [15:0] presc_r;
  logic [63:0] mtime_r;
  logic [63:0] cmp_r;
  logic        en_r;
  logic        irq_r;
  logic        tick_s;
  logic        strb_any_s;
  logic [63:0] mtime_inc_s;
  logic [63:0] mtime_next_s;
  logic [63:0] cmp_next_s;
  logic        en_next_s;

  assign tick_s      = en_r && (presc_r == PRESC_LAST);
  assign strb_any_s  = (wr_strb != 4'b0000);
  assign mtime_inc_s = tick_s ? (mtime_r + 64'd1) : mtime_r;

  // Next-state for software-visible registers; a real mtime write replaces that cycle's increment
  always_comb begin
    mtime_next_s = mtime_inc_s;
    cmp_next_s   = cmp_r;
    en_next_s    = en_r;
    if (wr_en && strb_any_s) begin
      case (wr_idx)
        REG_MTIME_LO: mtime_next_s = {mtime_r[63:32], merge_strb(mtime_r[31:0], wr_data, wr_strb)};
        REG_MTIME_HI: mtime_next_s = {merge_strb(mtime_r[63:32], wr_data, wr_strb), mtime_r[31:0]};
        REG_CMP_LO:   cmp_next_s   = {cmp_r[63:32], merge_strb(cmp_r[31:0], wr_data, wr_strb)};
        REG_CMP_HI:   cmp_next_s   = {merge_strb(cmp_r[63:32], wr_data, wr_strb), cmp_r[31:0]};
        REG_CTRL: begin
          if (wr_strb[0]) begin
            en_next_s = wr_data[CTRL_EN_BIT];
          end else begin
            en_next_s = en_r;
          end
        end
        default: cmp_next_s = cmp_r;
      endcase
    end else begin
      mtime_next_s = mtime_inc_s;
    end
  end

  // Prescaler runs only while enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= 16'd0;
    end else if (en_r) begin
      presc_r <= tick_s ? 16'd0 : (presc_r + 16'd1);
    end else begin
      presc_r <= presc_r;
    end
  end

  // Timer registers and the interrupt level
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_r <= 64'd0;
      cmp_r   <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_r    <= 1'b0;
      irq_r   <= 1'b0;
    end else begin
      mtime_r <= mtime_next_s;
      cmp_r   <= cmp_next_s;
      en_r    <= en_next_s;
      irq_r   <= en_r & (mtime_r >= cmp_r);
    end
  end

  assign mtime = mtime_r;
  assign cmp   = cmp_r;
  assign en    = en_r;
  assign irq   = irq_r;

endmodule

// File: rtl/axil_timer.sv
// AXI-Lite slave front end for the machine timer: channel handshakes, address decode,
// read mux with an mtime high-word shadow for atomic 64-bit reads.
module axil_timer
  import emu_periph_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int PRESCALE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axilite_awaddr,
  input  logic [2:0]            s_axilite_awprot,
  input  logic                  s_axilite_awvalid,
  output logic                  s_axilite_awready,
  input  logic [31:0]           s_axilite_wdata,
  input  logic [3:0]            s_axilite_wstrb,
  input  logic                  s_axilite_wvalid,
  output logic                  s_axilite_wready,
  output logic [1:0]            s_axilite_bresp,
  output logic                  s_axilite_bvalid,
  input  logic                  s_axilite_bready,
  input  logic [ADDR_WIDTH-1:0] s_axilite_araddr,
  input  logic [2:0]            s_axilite_arprot,
  input  logic                  s_axilite_arvalid,
  output logic                  s_axilite_arready,
  output logic [31:0]           s_axilite_rdata,
  output logic [1:0]            s_axilite_rresp,
  output logic                  s_axilite_rvalid,
  input  logic                  s_axilite_rready,
  output logic                  irq
);

  logic        alive_r;
  logic        aw_held_r;
  logic [2:0]  aw_idx_r;
  logic        w_held_r;
  logic [31:0] w_data_r;
  logic [3:0]  w_strb_r;
  logic        bvalid_r;
  logic [1:0]  bresp_r;
  logic        rvalid_r;
  logic [1:0]  rresp_r;
  logic [31:0] rdata_r;
  logic [31:0] shadow_r;

  logic        aw_hs_s;
  logic        w_hs_s;
  logic        ar_hs_s;
  logic        commit_s;
  logic [2:0]  wr_idx_s;
  logic [31:0] wr_data_s;
  logic [3:0]  wr_strb_s;
  logic        wr_mapped_s;
  logic [2:0]  rd_idx_s;
  logic        rd_mapped_s;
  logic [31:0] rd_data_s;
  logic [63:0] mtime_s;
  logic [63:0] cmp_s;
  logic        en_s;
  logic        unused_s;

  assign unused_s = ^{s_axilite_awprot, s_axilite_arprot, s_axilite_awaddr, s_axilite_araddr};

  // alive_r keeps every ready low through reset and for the edge that ends it
  assign s_axilite_awready = alive_r & ~aw_held_r & ~bvalid_r;
  assign s_axilite_wready  = alive_r & ~w_held_r & ~bvalid_r;
  assign s_axilite_arready = alive_r & ~rvalid_r;

  assign aw_hs_s = s_axilite_awvalid & s_axilite_awready;
  assign w_hs_s  = s_axilite_wvalid & s_axilite_wready;
  assign ar_hs_s = s_axilite_arvalid & s_axilite_arready;

  assign commit_s    = (aw_held_r | aw_hs_s) & (w_held_r | w_hs_s);
  assign wr_idx_s    = aw_held_r ? aw_idx_r : s_axilite_awaddr[4:2];
  assign wr_data_s   = w_held_r ? w_data_r : s_axilite_wdata;
  assign wr_strb_s   = w_held_r ? w_strb_r : s_axilite_wstrb;
  assign wr_mapped_s = idx_mapped(wr_idx_s);

  assign rd_idx_s    = s_axilite_araddr[4:2];
  assign rd_mapped_s = idx_mapped(rd_idx_s);

  axil_timer_core #(
    .PRESCALE (PRESCALE)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (commit_s & wr_mapped_s),
    .wr_idx  (wr_idx_s),
    .wr_data (wr_data_s),
    .wr_strb (wr_strb_s),
    .mtime   (mtime_s),
    .cmp     (cmp_s),
    .en      (en_s),
    .irq     (irq)
  );

  // Read mux sees pre-write register values, so a same-cycle write never leaks into rdata
  always_comb begin
    rd_data_s = 32'd0;
    case (rd_idx_s)
      REG_MTIME_LO: rd_data_s = mtime_s[31:0];
      REG_MTIME_HI: rd_data_s = shadow_r;
      REG_CMP_LO:   rd_data_s = cmp_s[31:0];
      REG_CMP_HI:   rd_data_s = cmp_s[63:32];
      REG_CTRL:     rd_data_s = {31'd0, en_s};
      default:      rd_data_s = 32'd0;
    endcase
  end

  // Write channel capture, commit and response
  always_ff @(posedge clk) begin
    if (rst) begin
      alive_r   <= 1'b0;
      aw_held_r <= 1'b0;
      aw_idx_r  <= 3'd0;
      w_held_r  <= 1'b0;
      w_data_r  <= 32'd0;
      w_strb_r  <= 4'd0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      alive_r <= 1'b1;
      if (commit_s) begin
        aw_held_r <= 1'b0;
        w_held_r  <= 1'b0;
        bvalid_r  <= 1'b1;
        bresp_r   <= wr_mapped_s ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs_s) begin
          aw_held_r <= 1'b1;
          aw_idx_r  <= s_axilite_awaddr[4:2];
        end
        if (w_hs_s) begin
          w_held_r <= 1'b1;
          w_data_r <= s_axilite_wdata;
          w_strb_r <= s_axilite_wstrb;
        end
        if (bvalid_r && s_axilite_bready) begin
          bvalid_r <= 1'b0;
        end
      end
    end
  end

  // Read channel; an MTIME_LO read snapshots the high word for the following MTIME_HI read
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'd0;
      rresp_r  <= RESP_OKAY;
      shadow_r <= 32'd0;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rd_data_s;
      rresp_r  <= rd_mapped_s ? RESP_OKAY : RESP_SLVERR;
      if (rd_idx_s == REG_MTIME_LO) begin
        shadow_r <= mtime_s[63:32];
      end
    end else if (rvalid_r && s_axilite_rready) begin
      rvalid_r <= 1'b0;
    end
  end

  assign s_axilite_bvalid = bvalid_r;
  assign s_axilite_bresp  = bresp_r;
  assign s_axilite_rvalid = rvalid_r;
  assign s_axilite_rdata  = rdata_r;
  assign s_axilite_rresp  = rresp_r;

endmodule

// File: doc/axil_timer.md
AXIL_TIMER -- requirements
Module: axil_timer

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AXI-Lite address width; only addr[4:2] decoded.
REQ-002 Parameter PRESCALE, default 1, clk cycles per mtime increment; range 1..65535.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_axilite_aw{addr,prot,valid,ready}  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel.
REQ-006 s_axilite_w{data,strb,valid,ready}  in/in/in/out  32/4/1/1  write data channel.
REQ-007 s_axilite_b{resp,valid,ready}  out/out/in  2/1/1  write response channel.
REQ-008 s_axilite_ar{addr,prot,valid,ready}  in/in/in/out  ADDR_WIDTH/3/1/1  read address channel.
REQ-009 s_axilite_r{data,resp,valid,ready}  out/out/out/in  32/2/1/1  read data channel.
REQ-010 irq  output  1  timer interrupt, level, registered.

Function
REQ-011 Register map (word offsets): 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 CMP_LO, 0x0C CMP_HI, 0x10 CTRL (bit0 EN, others RAZ/WI); 0x14-0x1C unmapped.
REQ-012 Prescaler counts 0..PRESCALE-1 while EN=1; mtime (64 bit) increments by 1 on the wrap cycle, wraps 2^64-1 -> 0; EN=0 freezes both counters.
REQ-013 irq registered as EN & (mtime >= cmp), unsigned 64-bit compare; updates one cycle after any operand change.
REQ-014 Write path: awready and wready each high while its channel is not yet captured and bvalid=0; AW and W accepted in any order or same cycle.
REQ-015 Write commits in the cycle both are captured; bvalid asserts next cycle, held until bready; no new AW/W accepted while bvalid=1.
REQ-016 Writes honour wstrb per byte; wstrb=0 commits nothing but still responds OKAY.
REQ-017 Software write to MTIME_LO/HI in the same cycle as an increment: write wins, that increment dropped; prescaler unaffected.
REQ-018 Read path: arready = !rvalid; rdata/rresp registered, rvalid asserts cycle after AR handshake, held stable until rready.
REQ-019 Reading MTIME_LO latches mtime[63:32] into a shadow; MTIME_HI read returns the shadow (atomic 64-bit read LO then HI).
REQ-020 Unmapped offset: reads return 0 with resp SLVERR (2'b10); writes ignored with bresp SLVERR; mapped accesses OKAY (2'b00).
REQ-021 awprot/arprot ignored.
REQ-022 Simultaneous read and write in one cycle both proceed; read returns the pre-write value.

Reset
REQ-023 On rst=1 at a clock edge: mtime=0, cmp=64'hFFFF_FFFF_FFFF_FFFF, EN=0, prescaler=0, shadow=0, irq=0.
REQ-024 Reset outputs: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rdata=0, bresp=rresp=0; ready signals rise the first cycle after rst deasserts.
REQ-025 rst mid-transaction discards any captured AW/W and pending B/R responses without completing them.

Structure
REQ-026 Register offsets, CTRL bit positions and AXI resp codes (OKAY, SLVERR) live in shared package emu_periph_pkg.
REQ-027 One sub-module axil_timer_core holds prescaler, mtime, cmp, compare and irq; the top holds AXI-Lite handshake and decode.
REQ-028 Block attaches as an additional master port of the AXI-Lite interconnect beside RAM and UART.

Verification
REQ-029 PRESCALE=4: write CTRL=1, wait 40 cycles -> MTIME_LO reads 10 (+/-1 for read latency).
REQ-030 Write CMP_HI=0, CMP_LO=20, CTRL=1, PRESCALE=1 -> irq rises exactly one cycle after mtime reaches 20; write CMP_LO=0xFFFFFFFF and CMP_HI=0xFFFFFFFF -> irq falls.
REQ-031 Set MTIME_LO=0xFFFFFFFF, MTIME_HI=0, EN=1, PRESCALE=1 -> after increment read LO=0, HI=1; LO then HI read across carry returns consistent pair.
REQ-032 W valid 3 cycles before AW, bready held low 5 cycles -> single commit, bvalid held 5 cycles, no second acceptance meanwhile.
REQ-033 Read 0x18 -> rdata=0, rresp=2'b10; write 0x18 with wstrb=4'hF -> bresp=2'b10, no register change.
REQ-034 Assert rst while bvalid=1 and rvalid=1 -> both 0 the next cycle, mtime=0, irq=0.
